// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender (sign/zero/upper/branch) with valid/ready and a skid entry
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);
    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext, zext, uext, bext, ext_data;
    logic             accept, out_free;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [1:0]       out_mode_q, out_mode_d, skid_mode_q, skid_mode_d;

    // Extended value of the presented immediate in all four modes, then pick by mode
    always_comb begin
        sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        zext     = {{EXT_W{1'b0}}, in_imm};
        uext     = {in_imm, {EXT_W{1'b0}}};
        bext     = {sext[OUT_W-3:0], 2'b00};
        ext_data = in_mode == 2'b00 ? sext :
                   in_mode == 2'b01 ? zext :
                   in_mode == 2'b10 ? uext : bext;
    end

    // Handshake: ready depends only on held state and flush, never on out_ready
    always_comb begin
        in_ready = !skid_valid_q && !flush;
        accept   = in_valid && in_ready;
        out_free = !out_valid_q || out_ready;
    end

    // Next state: skid drains first to keep FIFO order; new data lands in the skid only when the output is stalled
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            out_valid_d = skid_valid_q || accept;
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d = ext_data;
                out_mode_d = in_mode;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
            skid_mode_d  = in_mode;
        end
    end

    // Output and skid registers; reset drops every held entry immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mode_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: randomized and directed check of imm_extend_pipe against a queue-based reference model
module tb_imm_extend_pipe;
    logic        clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [15:0] in_imm = 0;
    logic [1:0]  in_mode = 0, out_mode;
    logic [31:0] out_data;

    logic        v8 = 0, ordy8 = 1, flush8 = 0, rdy8, valid8;
    logic [7:0]  imm8 = 0;
    logic [1:0]  mode8 = 0, mode8o;
    logic [15:0] data8;

    int n_checks = 0, n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mode;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush8),
        .in_valid(v8), .in_ready(rdy8), .in_imm(imm8), .in_mode(mode8),
        .out_valid(valid8), .out_ready(ordy8), .out_data(data8), .out_mode(mode8o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Extension defined arithmetically: signed value, plain value, scaled value, signed*4, all mod 2**ow
    function automatic logic [31:0] ref_ext(input int unsigned imm, input int mode, input int iw, input int ow);
        longint s, r;
        s = (imm >= (32'd1 << (iw - 1))) ? longint'(imm) - (longint'(1) << iw) : longint'(imm);
        r = mode == 0 ? s : mode == 1 ? longint'(imm) :
            mode == 2 ? longint'(imm) * (longint'(1) << (ow - iw)) : s * 4;
        return 32'(r & ((longint'(1) << ow) - 1));
    endfunction

    // One cycle: drive inputs after the falling edge, check registered state, then advance the model past the next rising edge
    task automatic drive_cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic ordy, input logic fl);
        item_t it;
        logic  acc, xfer;
        @(negedge clk);
        in_valid  = v;
        in_imm    = v ? imm : 16'($urandom);
        in_mode   = v ? mode : 2'($urandom);
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2 && !fl);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_mode", out_mode, q[0].mode);
        end
        xfer = q.size() != 0 && ordy;
        acc  = v && q.size() < 2 && !fl;
        if (xfer) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) begin
            it.data = ref_ext(imm, mode, 16, 32);
            it.mode = mode;
            q.push_back(it);
        end
    endtask

    task automatic one(input string tag, input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        drive_cycle(1, imm, mode, 1, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_data, exp);
    endtask

    task automatic one8(input string tag, input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] exp);
        @(negedge clk);
        v8 = 1; imm8 = imm; mode8 = mode;
        #1 chk("u8_ready", rdy8, 1);
        @(negedge clk);
        v8 = 0; imm8 = 8'($urandom);
        #1 chk("u8_valid", valid8, 1);
        chk(tag, data8, exp);
        chk({tag, "_ref"}, data8, ref_ext(imm, mode, 8, 16));
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_mode", out_mode, 0);
        #20 reset_n = 1;
        // mode vectors, each visible one cycle after accept
        one("sign_neg", 16'hFBFF, 2'b00, 32'hFFFFFBFF);
        one("sign_pos", 16'h000D, 2'b00, 32'h0000000D);
        one("zero", 16'hF101, 2'b01, 32'h0000F101);
        one("upper", 16'h1234, 2'b10, 32'h12340000);
        one("branch", 16'hFFFF, 2'b11, 32'hFFFFFFFC);
        drive_cycle(0, 0, 0, 1, 0);
        // streaming
        drive_cycle(1, 16'hFBFF, 0, 1, 0);
        drive_cycle(1, 16'hF101, 0, 1, 0);
        drive_cycle(1, 16'h000D, 0, 1, 0);
        drive_cycle(1, 16'h0000, 0, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        // backpressure: third item refused until downstream drains
        drive_cycle(1, 16'h8001, 0, 0, 0);
        drive_cycle(1, 16'h0042, 1, 0, 0);
        drive_cycle(1, 16'h7777, 3, 0, 0);
        drive_cycle(1, 16'h7777, 3, 0, 0);
        chk("stall_hold", out_data, 32'hFFFF8001);
        chk("stall_ready", in_ready, 0);
        drive_cycle(1, 16'h7777, 3, 1, 0);
        drive_cycle(1, 16'h7777, 3, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        // flush with both entries held
        drive_cycle(1, 16'h1111, 0, 0, 0);
        drive_cycle(1, 16'h2222, 0, 0, 0);
        drive_cycle(1, 16'h3333, 0, 0, 1);
        drive_cycle(0, 0, 0, 1, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        drive_cycle(0, 0, 0, 1, 0);
        // async reset between edges with both entries held
        drive_cycle(1, 16'hAAAA, 2, 0, 0);
        drive_cycle(1, 16'h5555, 2, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_mode", out_mode, 0);
        chk("arst_ready", in_ready, 1);
        q.delete();
        #4 reset_n = 1;
        one("post_rst", 16'h8000, 2'b11, 32'hFFFE0000);
        drive_cycle(0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            drive_cycle(1'($urandom), 16'($urandom), 2'($urandom),
                        $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 0);
        // narrow variant
        one8("u8_sign", 8'h80, 2'b00, 16'hFF80);
        one8("u8_upper", 8'hAB, 2'b10, 16'hAB00);
        one8("u8_branch", 8'hFF, 2'b11, 16'hFFFC);
        one8("u8_zero", 8'h9C, 2'b01, 16'h009C);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath; generalises the fixed 16-to-32 sign extender.
- Four extension modes: sign, zero, upper (LUI) and branch offset. Widths are parametrised.
- Valid/ready handshake on both sides, with a 2-entry skid buffer, so it can sit between decode and execute under stalls.

Parameters:
IN_W, 16, immediate input width.
OUT_W, 32, result width; must satisfy OUT_W >= IN_W + 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush (branch mispredict / exception).
in_valid  input  1  upstream presents an immediate.
in_ready  output  1  block can accept this cycle.
in_imm  input  IN_W  raw immediate field.
in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
out_valid  output  1  out_data holds a valid result.
out_ready  input  1  downstream accepts this cycle.
out_data  output  OUT_W  extended result.
out_mode  output  2  mode that produced out_data.

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_data=0, out_mode=0, skid entry invalid and zeroed, so in_ready=1 once reset releases.
- Reset mid-operation discards all held entries immediately; nothing is replayed.
- Extension, combinational on the accepted input:
  - sign: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - zero: upper OUT_W-IN_W bits are 0.
  - upper: in_imm << (OUT_W-IN_W); low bits are 0.
  - branch: sign-extend, then shift left 2, truncated to OUT_W.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- in_ready = !skid_valid && !flush. This is registered state only; there is no combinational path from out_ready to in_ready.
- Latency: 1 cycle. An accept at edge N gives out_valid at N+1 if the output register was empty or transferring.
- Output register update per cycle (flush low):
  - Output empty or transferring, skid valid: output <= skid; skid cleared.
  - Output empty or transferring, skid empty, accept: output <= new result.
  - Output empty or transferring, nothing pending: out_valid <= 0.
  - Output full and stalled, accept: skid <= new result; output holds.
- Ordering is strictly FIFO. There is no drop and no duplication outside flush.
- out_data and out_mode stay stable while out_valid && !out_ready.
- Full: skid valid means in_ready=0. Throughput is 1 result/cycle while out_ready=1.
- flush high:
  - Next edge clears out_valid and skid_valid.
  - A transfer in the flush cycle still counts as delivered.
  - in_ready is 0 during flush, so no new accept occurs.
  - Data registers may hold stale values, but out_valid=0.
- Boundaries:
  - Accept and transfer in the same cycle with skid empty: the new result replaces the output, out_valid stays 1.
  - Skid valid and transfer: the skid moves to the output; in_ready rises the following cycle.
- X on in_imm or in_mode while in_valid=0 must not propagate to outputs.

Test Plan:
- Modes at IN_W=16, OUT_W=32, out_ready=1:
  - sign 0xFBFF -> 0xFFFFFBFF.
  - sign 0x000D -> 0x0000000D.
  - zero 0xF101 -> 0x0000F101.
  - upper 0x1234 -> 0x12340000.
  - branch 0xFFFF -> 0xFFFFFFFC.
  - Each result appears exactly 1 cycle after accept.
- Streaming: 4 back-to-back valids (0xFBFF, 0xF101, 0x000D, 0x0000; sign mode) with out_ready=1 -> four results on consecutive cycles, in order, in_ready constantly 1.
- Backpressure: hold out_ready=0 and send 3 items -> first 2 accepted (output + skid), in_ready=0 on the 3rd until out_ready=1. Then results arrive in order and out_data is stable throughout the stall.
- Flush with both entries full -> out_valid=0 and in_ready=1 one cycle later; no stale result ever emitted.
- Async reset asserted mid-stream between clock edges -> outputs are 0 immediately without a clock edge; after release the first new accept gives the correct result.
- Parameter variant IN_W=8, OUT_W=16:
  - sign 0x80 -> 0xFF80.
  - upper 0xAB -> 0xAB00.
  - branch 0xFF -> 0xFFFC.
